// File: rtl/output_streamer.sv
// -----------------------------------------------------------------------------
// output_streamer
// Ping-pong block buffer that receives a full block of DATA_OF_SET words from
// the output collector in one cycle and streams it out as WORDS_PER_BEAT-wide
// beats over a valid/ready interface, one beat per cycle when the sink allows.
// Optional build macro: OUTPUT_STREAMER_RELU_EN -- when defined, every output
// lane is clamped to zero if its word is negative (signed).
// -----------------------------------------------------------------------------
module output_streamer #(
   parameter int DATA_WIDTH     = 32,
   parameter int DATA_OF_SET    = 128,
   parameter int WORDS_PER_BEAT = 4,
   parameter int ADDR_WIDTH     = 16
) (
   input  logic                                       clk,
   input  logic                                       rst,
   input  logic [DATA_OF_SET-1:0][DATA_WIDTH-1:0]     din,
   input  logic                                       din_valid,
   input  logic [ADDR_WIDTH-1:0]                      base_addr,
   output logic [WORDS_PER_BEAT-1:0][DATA_WIDTH-1:0]  m_data,
   output logic [ADDR_WIDTH-1:0]                      m_addr,
   output logic                                       m_valid,
   input  logic                                       m_ready,
   output logic                                       busy,
   output logic                                       overflow
);

   localparam int BEATS  = DATA_OF_SET / WORDS_PER_BEAT;
   localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int IDX_W  = (DATA_OF_SET > 1) ? $clog2(DATA_OF_SET) : 1;
   localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(BEATS - 1);
   localparam logic [BEAT_W-1:0]     BEAT_ONE  = 1;
   localparam logic [BEAT_W-1:0]     BEAT_ZERO = 0;
   localparam logic [ADDR_WIDTH-1:0] BEATS_A   = ADDR_WIDTH'(BEATS);
   localparam logic [IDX_W-1:0]      WPB_I     = IDX_W'(WORDS_PER_BEAT);

   typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} state_t;

   state_t                                   state_r, state_n_s;
   logic [DATA_OF_SET-1:0][DATA_WIDTH-1:0]   buf_r [2];
   logic [ADDR_WIDTH-1:0]                    base_r [2];
   logic [1:0]                               full_r, full_n_s, free_s;
   logic                                     wr_ptr_r, rd_ptr_r, rd_ptr_n_s;
   logic [BEAT_W-1:0]                        beat_r, beat_n_s;
   logic [ADDR_WIDTH-1:0]                    block_cnt_r, block_cnt_n_s;
   logic                                     xfer_s, last_s, cap_s, drop_s;
   logic                                     cap_to_rd_s, valid_n_s;
   logic [ADDR_WIDTH-1:0]                    base_sel_s, addr_s;
   logic [WORDS_PER_BEAT-1:0][DATA_WIDTH-1:0] lanes_s;
   logic [IDX_W-1:0]                         word_idx_s;
   logic [WORDS_PER_BEAT-1:0][DATA_WIDTH-1:0] m_data_r;
   logic [ADDR_WIDTH-1:0]                    m_addr_r;
   logic                                     m_valid_r, busy_r, overflow_r;

   // Output lane transform: optional ReLU clamp on the signed word.
   function automatic logic [DATA_WIDTH-1:0] lane_fn(input logic [DATA_WIDTH-1:0] w);
`ifdef OUTPUT_STREAMER_RELU_EN
      if (w[DATA_WIDTH-1]) begin
         lane_fn = {DATA_WIDTH{1'b0}};
      end else begin
         lane_fn = w;
      end
`else
      lane_fn = w;
`endif
   endfunction

   // Handshake, capture decision and next-cycle bookkeeping.
   always_comb begin
      xfer_s    = m_valid_r & m_ready;
      last_s    = xfer_s & (beat_r == LAST_BEAT);
      // A buffer draining its final beat this cycle may be refilled this cycle.
      free_s[0] = ~full_r[0] | (last_s & ~rd_ptr_r);
      free_s[1] = ~full_r[1] | (last_s &  rd_ptr_r);
      cap_s     = din_valid & free_s[wr_ptr_r];
      drop_s    = din_valid & ~free_s[wr_ptr_r];
      full_n_s[0] = (full_r[0] & ~(last_s & ~rd_ptr_r)) | (cap_s & ~wr_ptr_r);
      full_n_s[1] = (full_r[1] & ~(last_s &  rd_ptr_r)) | (cap_s &  wr_ptr_r);
      rd_ptr_n_s  = rd_ptr_r ^ last_s;
      if (last_s) begin
         beat_n_s = BEAT_ZERO;
      end else if (xfer_s) begin
         beat_n_s = beat_r + BEAT_ONE;
      end else begin
         beat_n_s = beat_r;
      end
      block_cnt_n_s = block_cnt_r + ADDR_WIDTH'(last_s);
   end

   // Next-state logic: SEND as long as the buffer being read holds a block.
   always_comb begin
      state_n_s = state_r;
      case (state_r)
         IDLE: begin
            if (full_n_s[rd_ptr_n_s]) begin
               state_n_s = SEND;
            end else begin
               state_n_s = IDLE;
            end
         end
         SEND: begin
            if (last_s && !full_n_s[rd_ptr_n_s]) begin
               state_n_s = IDLE;
            end else begin
               state_n_s = SEND;
            end
         end
         default: state_n_s = IDLE;
      endcase
   end

   // Output logic: beat presented next cycle, bypassing din on a fresh capture.
   always_comb begin
      valid_n_s   = (state_n_s == SEND);
      cap_to_rd_s = cap_s & (wr_ptr_r == rd_ptr_n_s);
      if (cap_to_rd_s) begin
         base_sel_s = base_addr;
      end else begin
         base_sel_s = base_r[rd_ptr_n_s];
      end
      addr_s     = base_sel_s + (block_cnt_n_s * BEATS_A) + ADDR_WIDTH'(beat_n_s);
      word_idx_s = {IDX_W{1'b0}};
      lanes_s    = {(WORDS_PER_BEAT*DATA_WIDTH){1'b0}};
      for (int j = 0; j < WORDS_PER_BEAT; j++) begin
         word_idx_s = (IDX_W'(beat_n_s) * WPB_I) + IDX_W'(j);
         if (cap_to_rd_s) begin
            lanes_s[j] = lane_fn(din[word_idx_s]);
         end else begin
            lanes_s[j] = lane_fn(buf_r[rd_ptr_n_s][word_idx_s]);
         end
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_n_s;
      end
   end

   // Control registers and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full_r      <= 2'b00;
         wr_ptr_r    <= 1'b0;
         rd_ptr_r    <= 1'b0;
         beat_r      <= BEAT_ZERO;
         block_cnt_r <= {ADDR_WIDTH{1'b0}};
         m_valid_r   <= 1'b0;
         m_data_r    <= {(WORDS_PER_BEAT*DATA_WIDTH){1'b0}};
         m_addr_r    <= {ADDR_WIDTH{1'b0}};
         busy_r      <= 1'b0;
         overflow_r  <= 1'b0;
      end else begin
         full_r      <= full_n_s;
         wr_ptr_r    <= wr_ptr_r ^ cap_s;
         rd_ptr_r    <= rd_ptr_n_s;
         beat_r      <= beat_n_s;
         block_cnt_r <= block_cnt_n_s;
         m_valid_r   <= valid_n_s;
         if (valid_n_s) begin
            m_data_r <= lanes_s;
            m_addr_r <= addr_s;
         end
         busy_r      <= |full_n_s;
         overflow_r  <= overflow_r | drop_s;
      end
   end

   // Block storage; validity is carried by the full flags, so no reset needed.
   always_ff @(posedge clk) begin
      if (cap_s) begin
         buf_r[wr_ptr_r]  <= din;
         base_r[wr_ptr_r] <= base_addr;
      end
   end

   assign m_data   = m_data_r;
   assign m_addr   = m_addr_r;
   assign m_valid  = m_valid_r;
   assign busy     = busy_r;
   assign overflow = overflow_r;

endmodule

// File: tb/tb_output_streamer.sv
// -----------------------------------------------------------------------------
// tb_output_streamer
// Directed bench for output_streamer with a beat scoreboard: every accepted
// block pushes its expected beats; a negedge monitor pops them on transfers.
// Honours OUTPUT_STREAMER_RELU_EN in its lane model.
// -----------------------------------------------------------------------------
module tb_output_streamer;

   localparam int DW    = 32;
   localparam int NW    = 128;
   localparam int WPB   = 4;
   localparam int AW    = 16;
   localparam int BEATS = NW / WPB;

   typedef logic [NW-1:0][DW-1:0]  block_t;
   typedef logic [WPB-1:0][DW-1:0] beat_data_t;
   typedef struct packed {
      beat_data_t    data;
      logic [AW-1:0] addr;
   } exp_t;

   logic          clk;
   logic          rst;
   block_t        din;
   logic          din_valid;
   logic [AW-1:0] base_addr;
   beat_data_t    m_data;
   logic [AW-1:0] m_addr;
   logic          m_valid;
   logic          m_ready;
   logic          busy;
   logic          overflow;

   exp_t   q[$];
   int     checks     = 0;
   int     failures   = 0;
   int     beats_seen = 0;
   int     n_acc      = 0;
   block_t blk;
   logic [DW-1:0] exp_lane0;
   logic [DW-1:0] exp_lane1;

   output_streamer #(
      .DATA_WIDTH    (DW),
      .DATA_OF_SET   (NW),
      .WORDS_PER_BEAT(WPB),
      .ADDR_WIDTH    (AW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .din      (din),
      .din_valid(din_valid),
      .base_addr(base_addr),
      .m_data   (m_data),
      .m_addr   (m_addr),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .busy     (busy),
      .overflow (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [DW-1:0] model_lane(input logic [DW-1:0] w);
`ifdef OUTPUT_STREAMER_RELU_EN
      return ($signed(w) < 0) ? 32'h0000_0000 : w;
`else
      return w;
`endif
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one din_valid pulse; when the block should be accepted, queue its beats.
   task automatic pulse(input block_t b, input logic [AW-1:0] base, input bit accept);
      exp_t e;
      din       = b;
      base_addr = base;
      din_valid = 1'b1;
      if (accept) begin
         for (int k = 0; k < BEATS; k++) begin
            for (int j = 0; j < WPB; j++) e.data[j] = model_lane(b[k*WPB + j]);
            e.addr = base + AW'(n_acc*BEATS + k);
            q.push_back(e);
         end
         n_acc++;
      end
      tick();
      din_valid = 1'b0;
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while ((q.size() != 0 || m_valid) && n < 2000) begin
         tick();
         n++;
      end
      chk({tag, "_empty"}, q.size(), 0);
      chk({tag, "_valid"}, m_valid, 0);
      chk({tag, "_busy"}, busy, 0);
   endtask

   // Scoreboard monitor: a beat transfers at the next edge when valid and ready.
   always @(negedge clk) begin
      if (!rst && m_valid && m_ready) begin
         if (q.size() == 0) begin
            chk("unexpected_beat", 1, 0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("beat_data", m_data, e.data);
            chk("beat_addr", m_addr, e.addr);
            beats_seen++;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog time limit expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b1;
      din_valid = 1'b0;
      m_ready   = 1'b1;
      din       = '0;
      base_addr = '0;
      repeat (3) tick();
      chk("rst_valid", m_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_data", m_data, 0);
      chk("rst_addr", m_addr, 0);
      rst = 1'b0;
      tick();

      // Basic block: word i = i, base 0x100, sink always ready.
      for (int i = 0; i < NW; i++) blk[i] = DW'(i);
      beats_seen = 0;
      pulse(blk, 16'h0100, 1'b1);
      chk("t1_first_valid", m_valid, 1);
      chk("t1_first_data", m_data, 128'h00000003_00000002_00000001_00000000);
      chk("t1_first_addr", m_addr, 16'h0100);
      chk("t1_busy", busy, 1);
      drain("t1");
      chk("t1_beats", beats_seen, 32);

      // Backpressure at beat 7 for five cycles.
      for (int i = 0; i < NW; i++) blk[i] = 32'h1000_0000 + DW'(i*3);
      beats_seen = 0;
      pulse(blk, 16'h0200, 1'b1);
      repeat (7) tick();
      m_ready = 1'b0;
      chk("t2_stall_addr", m_addr, 16'h0227);
      for (int s = 0; s < 5; s++) begin
         tick();
         chk("t2_hold_valid", m_valid, 1);
         chk("t2_hold_data", m_data, q[0].data);
         chk("t2_hold_addr", m_addr, q[0].addr);
      end
      chk("t2_queue", q.size(), 25);
      m_ready = 1'b1;
      drain("t2");
      chk("t2_beats", beats_seen, 32);

      // Three back-to-back pulses against a stalled sink; address wraps.
      m_ready = 1'b0;
      for (int i = 0; i < NW; i++) blk[i] = 32'h00A0_0000 + DW'(i);
      pulse(blk, 16'hFFF0, 1'b1);
      for (int i = 0; i < NW; i++) blk[i] = 32'h00B0_0000 + DW'(i);
      pulse(blk, 16'hFFF0, 1'b1);
      chk("t3_no_ovf_yet", overflow, 0);
      for (int i = 0; i < NW; i++) blk[i] = 32'h00C0_0000 + DW'(i);
      pulse(blk, 16'hFFF0, 1'b0);
      chk("t3_ovf", overflow, 1);
      chk("t3_busy", busy, 1);
      chk("t3_valid", m_valid, 1);
      chk("t3_addr_wrap", m_addr, 16'h0030);
      repeat (3) tick();
      chk("t3_addr_held", m_addr, 16'h0030);
      m_ready    = 1'b1;
      beats_seen = 0;
      drain("t3");
      chk("t3_beats", beats_seen, 64);
      chk("t3_ovf_sticky", overflow, 1);

      // Reset in the middle of a block, with din_valid ignored during reset.
      for (int i = 0; i < NW; i++) blk[i] = 32'h0000_0500 + DW'(i);
      pulse(blk, 16'h0400, 1'b1);
      repeat (10) tick();
      rst = 1'b1;
      #1;
      chk("t5_rst_valid", m_valid, 0);
      chk("t5_rst_busy", busy, 0);
      chk("t5_rst_ovf", overflow, 0);
      chk("t5_rst_addr", m_addr, 0);
      chk("t5_rst_data", m_data, 0);
      q.delete();
      n_acc = 0;
      tick();
      pulse(blk, 16'h0777, 1'b0);
      rst = 1'b0;
      tick();
      chk("t5_ignored_valid", m_valid, 0);
      chk("t5_ignored_busy", busy, 0);
      beats_seen = 0;
      pulse(blk, 16'h0400, 1'b1);
      chk("t5_restart_addr", m_addr, 16'h0400);
      chk("t5_restart_data", m_data, 128'h00000503_00000502_00000501_00000500);
      drain("t5");
      chk("t5_beats", beats_seen, 32);

      // Capture in the cycle of the final beat while the other buffer is full.
      beats_seen = 0;
      for (int i = 0; i < NW; i++) blk[i] = 32'h0000_3000 + DW'(i);
      pulse(blk, 16'h0300, 1'b1);
      for (int i = 0; i < NW; i++) blk[i] = 32'h0000_4000 + DW'(i);
      pulse(blk, 16'h0300, 1'b1);
      repeat (30) tick();
      chk("t4_final_addr", m_addr, 16'h033F);
      chk("t4_busy", busy, 1);
      for (int i = 0; i < NW; i++) blk[i] = 32'h0000_5000 + DW'(i);
      pulse(blk, 16'h0300, 1'b1);
      chk("t4_no_ovf", overflow, 0);
      chk("t4_next_addr", m_addr, 16'h0340);
      drain("t4");
      chk("t4_beats", beats_seen, 96);
      chk("t4_no_ovf_end", overflow, 0);

      // Negative words through the optional clamp.
      for (int i = 0; i < NW; i++) blk[i] = DW'(i);
      blk[0] = 32'hFFFF_FFFF;
      blk[1] = 32'h8000_0000;
      blk[2] = 32'h7FFF_FFFF;
`ifdef OUTPUT_STREAMER_RELU_EN
      exp_lane0 = 32'h0000_0000;
      exp_lane1 = 32'h0000_0000;
`else
      exp_lane0 = 32'hFFFF_FFFF;
      exp_lane1 = 32'h8000_0000;
`endif
      pulse(blk, 16'h0000, 1'b1);
      chk("t6_lane0", m_data[0], exp_lane0);
      chk("t6_lane1", m_data[1], exp_lane1);
      chk("t6_lane2", m_data[2], 32'h7FFF_FFFF);
      drain("t6");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
